result_seg_encoder: RTL and testbench

Sequential converter from a signed binary calculator result to three 7-segment digit codes. It sits directly upstream of the display scanner and produces the 24-bit segment word `seg`, with `seg[23:16]` as the leftmost digit. Conversion uses a multi-cycle shift-and-add-3 (double-dabble) BCD core, followed by an encode step that applies sign, leading-zero blanking and overflow indication. Handshake is start/busy/done; `seg` holds its last value between conversions.

---
 rtl/calc_seg_pkg.sv | 29 ++
 rtl/bin2bcd_seq.sv | 42 ++++
 rtl/result_seg_encoder.sv | 115 +++++++++++
 tb/tb_result_seg_encoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/calc_seg_pkg.sv
// Shared constants, digit table and FSM state type for the result-to-segment path.
// Latency: none (package only).
// Backpressure: not applicable.
package calc_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_E     = 8'h79;

  // Segment codes {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element of the packed array.
  localparam logic [9:0][7:0] DIGIT_CODES = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENC
  } state_t;

  // Non-decimal nibbles cannot occur for in-range values; show E if one ever does.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] code;
    code = SEG_E;
    if (d <= 4'd9) code = DIGIT_CODES[d];
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: N_ITER-bit magnitude to three BCD nibbles.
// Latency: one step per input bit; bcd is final after N_ITER steps following load.
// Backpressure: none; the caller sequences load and step.
module bin2bcd_seq #(
  parameter int N_ITER = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [N_ITER-1:0] mag,
  output logic [11:0]       bcd
);

  logic [N_ITER-1:0] bin_sr;
  logic [11:0]       bcd_sr;
  logic [11:0]       bcd_adj;

  // Add 3 to every nibble that would reach 10 or more after the next doubling.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
  end

  // Load clears the BCD side; each step shifts the adjusted BCD and binary as one word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (load) begin
      bin_sr <= mag;
      bcd_sr <= '0;
    end else if (step) begin
      {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
    end
  end

  assign bcd = bcd_sr;

endmodule

// File: rtl/result_seg_encoder.sv
// Signed result to three 7-segment digit codes with sign, blanking and overflow (EEE).
// Latency: 11 edges from the accepting start edge to the done pulse; seg holds between conversions.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module result_seg_encoder
  import calc_seg_pkg::*;
#(
  parameter int W_IN   = 11,
  parameter int N_ITER = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W_IN-1:0] val,
  output logic            busy,
  output logic            done,
  output logic [23:0]     seg
);

  localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);
  localparam logic signed [W_IN-1:0] VAL_MAX = W_IN'(999);
  localparam logic signed [W_IN-1:0] VAL_MIN = W_IN'(-99);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              oor_q;
  logic              out_of_range;
  logic [N_ITER-1:0] mag_in;
  logic              load;
  logic              step;
  logic [11:0]       bcd;
  logic [23:0]       seg_next;

  // Range flag and magnitude come straight from val; both are captured on the accepting edge.
  always_comb begin
    out_of_range = ($signed(val) > VAL_MAX) || ($signed(val) < VAL_MIN);
    mag_in       = N_ITER'(val[W_IN-1] ? (~val + W_IN'(1)) : val);
  end

  assign load = (state == IDLE) && start;
  assign step = (state == CONV);

  bin2bcd_seq #(
    .N_ITER(N_ITER)
  ) u_bcd (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(step),
    .mag (mag_in),
    .bcd (bcd)
  );

  // Build the display word: blank leading zeros, place the minus sign, or force EEE.
  always_comb begin
    logic [3:0] h, t, u;
    logic [7:0] d2, d1, d0;
    h  = bcd[11:8];
    t  = bcd[7:4];
    u  = bcd[3:0];
    d0 = digit_seg(u);
    d1 = (h == 4'd0 && t == 4'd0) ? SEG_BLANK : digit_seg(t);
    d2 = (h == 4'd0) ? SEG_BLANK : digit_seg(h);
    if (neg_q) begin
      // Negative in-range values are at most two digits, so h is always zero here.
      if (t != 4'd0) begin
        d2 = SEG_MINUS;
      end else begin
        d2 = SEG_BLANK;
        d1 = SEG_MINUS;
      end
    end
    seg_next = {d2, d1, d0};
    if (oor_q) seg_next = {SEG_E, SEG_E, SEG_E};
  end

  // Control FSM with registered busy/done/seg; seg only changes on the ENC edge or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      oor_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      seg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q <= val[W_IN-1];
            oor_q <= out_of_range;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          if (cnt == CNT_LAST) state <= ENC;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        ENC: begin
          seg   <= seg_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_seg_encoder.sv
module tb_result_seg_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] val;
  logic        busy;
  logic        done;
  logic [23:0] seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] v;
    logic [23:0] exp_seg;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  result_seg_encoder #(
    .W_IN  (11),
    .N_ITER(10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .val  (val),
    .busy (busy),
    .done (done),
    .seg  (seg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Called 1ns after an edge; start is sampled on the following edge.
  task automatic issue(input logic [10:0] v);
    start = 1'b1;
    val   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    val   = 11'($urandom);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int e;
    int bad;
    int ndone;
    int first_done;

    tbl[0]  = '{11'd0,      24'h00003F};
    tbl[1]  = '{11'd7,      24'h000007};
    tbl[2]  = '{11'd42,     24'h00665B};
    tbl[3]  = '{11'd999,    24'h6F6F6F};
    tbl[4]  = '{11'(-5),    24'h00406D};
    tbl[5]  = '{11'(-42),   24'h40665B};
    tbl[6]  = '{11'(-99),   24'h406F6F};
    tbl[7]  = '{11'd1000,   24'h797979};
    tbl[8]  = '{11'd1023,   24'h797979};
    tbl[9]  = '{11'(-100),  24'h797979};
    tbl[10] = '{11'(-1024), 24'h797979};

    rst   = 1'b1;
    start = 1'b0;
    val   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_seg", {8'h0, seg}, 32'h000000);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (seg !== 24'h0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 0);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].v);
      check($sformatf("busy_after_start[%0d]", i), {31'h0, busy}, 32'h1);
      wait_done(e);
      check($sformatf("latency[%0d]", i), e, 11);
      check($sformatf("seg[%0d]", i), {8'h0, seg}, {8'h0, tbl[i].exp_seg});
      check($sformatf("busy_at_done[%0d]", i), {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("done_pulse_width[%0d]", i), {31'h0, done}, 32'h0);
      check($sformatf("seg_hold[%0d]", i), {8'h0, seg}, {8'h0, tbl[i].exp_seg});
    end

    // start pulses on edges 3 and 6 of a conversion must be dropped.
    issue(11'd42);
    ndone      = 0;
    first_done = -1;
    for (int k = 1; k <= 30; k++) begin
      start = 1'b0;
      if (k == 2 || k == 5) begin
        start = 1'b1;
        val   = 11'd999;
      end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
    start = 1'b0;
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_latency", first_done, 11);
    check("ignored_start_seg", {8'h0, seg}, 32'h00665B);

    // start on the done cycle is accepted.
    issue(11'd999);
    wait_done(e);
    check("b2b_first_done", {31'h0, done}, 32'h1);
    issue(11'd7);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    wait_done(e);
    check("b2b_latency", e, 11);
    check("b2b_seg", {8'h0, seg}, 32'h000007);

    // Reset during a conversion of 999 aborts it and blanks the display.
    issue(11'd999);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_seg", {8'h0, seg}, 32'h000000);
    check("abort_busy", {31'h0, busy}, 32'h0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", ndone, 0);
    check("abort_seg_after_wait", {8'h0, seg}, 32'h000000);

    issue(11'd123);
    wait_done(e);
    check("restart_latency", e, 11);
    check("restart_seg", {8'h0, seg}, 32'h065B4F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
